// File: rtl/ldpc_io_sequencer_pkg.sv
// Shared definitions for the LDPC I/O sequencer: FSM encoding and derived widths.
package ldpc_io_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    START  = 3'd3,
    DECODE = 3'd4,
    RDADDR = 3'd5,
    RDWAIT = 3'd6,
    OUT    = 3'd7
  } seq_state_e;

  function automatic int ldpc_aw(input int foldfactor);
    return 7 + foldfactor;
  endfunction

  function automatic int ldpc_beats(input int numinstances, input int lanes);
    return numinstances / lanes;
  endfunction

  // Counter width that still holds value n-1 when n is 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ldpc_io_sequencer_pack.sv
// Gathers LANES-wide input beats into one full decoder word, tracking the beat index.
module ldpc_seq_pack
  import ldpc_io_sequencer_pkg::*;
#(
  parameter int NUMINSTANCES = 360,
  parameter int LLRWIDTH     = 6,
  parameter int LANES        = 30
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_i,
  input  logic                             beat_i,
  input  logic [LANES*LLRWIDTH-1:0]        data_i,
  output logic [NUMINSTANCES*LLRWIDTH-1:0] word_o,
  output logic                             last_beat_o
);

  localparam int BEATS = ldpc_beats(NUMINSTANCES, LANES);
  localparam int BW    = cnt_w(BEATS);
  localparam int BEATW = LANES * LLRWIDTH;

  logic [BW-1:0]                     beat_q, beat_d;
  logic [NUMINSTANCES*LLRWIDTH-1:0]  word_q, word_d;

  assign last_beat_o = (beat_q == BW'(BEATS - 1));
  assign word_o      = word_q;

  always_comb begin
    beat_d = beat_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (beat_i) begin
      beat_d = last_beat_o ? '0 : beat_q + BW'(1);
    end
  end

  // Each beat owns a fixed slice of the word; only the slice matching the beat index loads.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
    assign word_d[gi*BEATW +: BEATW] =
      (beat_i && !clear_i && beat_q == BW'(gi)) ? data_i : word_q[gi*BEATW +: BEATW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      word_q <= '0;
    end else begin
      beat_q <= beat_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/ldpc_io_sequencer.sv
// Frame sequencer: streams LLRs into decoder memory, launches a decode, streams hard decisions out.
module ldpc_io_sequencer
  import ldpc_io_sequencer_pkg::*;
#(
  parameter int FOLDFACTOR   = 4,
  parameter int NUMINSTANCES = 360,
  parameter int LLRWIDTH     = 6,
  parameter int LANES        = 30,
  parameter int RDLAT        = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_go,
  input  logic [ldpc_aw(FOLDFACTOR)-1:0]      cfg_words,
  input  logic [4:0]                          cfg_mode,
  input  logic [5:0]                          cfg_iter,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [LANES*LLRWIDTH-1:0]           s_data,
  output logic                                llr_access,
  output logic [ldpc_aw(FOLDFACTOR)-1:0]      llr_addr,
  output logic                                llr_din_we,
  output logic [NUMINSTANCES*LLRWIDTH-1:0]    llr_din,
  input  logic [NUMINSTANCES*LLRWIDTH-1:0]    llr_dout,
  output logic                                start,
  output logic [4:0]                          mode,
  output logic [5:0]                          iter_limit,
  input  logic                                done,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [NUMINSTANCES-1:0]             m_data,
  output logic                                m_last,
  output logic                                busy
);

  localparam int AW = ldpc_aw(FOLDFACTOR);
  localparam int WW = cnt_w(RDLAT);

  seq_state_e              state_q, state_d;
  logic [AW-1:0]           words_q, words_d;
  logic [4:0]              mode_q, mode_d;
  logic [5:0]              iter_q, iter_d;
  logic [AW-1:0]           wcnt_q, wcnt_d;
  logic [AW-1:0]           rcnt_q, rcnt_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [NUMINSTANCES-1:0] mdata_q, mdata_d;
  logic                    mlast_q, mlast_d;

  logic                    pack_clear;
  logic                    pack_last;
  logic                    beat;
  logic [NUMINSTANCES-1:0] sign_bits;
  logic                    unused_dout;

  assign beat = s_valid && s_ready;

  ldpc_seq_pack #(
    .NUMINSTANCES(NUMINSTANCES),
    .LLRWIDTH    (LLRWIDTH),
    .LANES       (LANES)
  ) u_pack (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (pack_clear),
    .beat_i     (beat),
    .data_i     (s_data),
    .word_o     (llr_din),
    .last_beat_o(pack_last)
  );

  for (genvar gi = 0; gi < NUMINSTANCES; gi++) begin : g_sign
    assign sign_bits[gi] = llr_dout[gi*LLRWIDTH + LLRWIDTH - 1];
  end
  // Only the sign bits feed the hard decisions; magnitudes are intentionally dropped.
  assign unused_dout = ^llr_dout;

  always_comb begin
    state_d    = state_q;
    words_d    = words_q;
    mode_d     = mode_q;
    iter_d     = iter_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    wait_d     = wait_q;
    mdata_d    = mdata_q;
    mlast_d    = mlast_q;
    pack_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_go && cfg_words != '0) begin
          words_d    = cfg_words;
          mode_d     = cfg_mode;
          iter_d     = cfg_iter;
          wcnt_d     = '0;
          rcnt_d     = '0;
          pack_clear = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (beat && pack_last) state_d = WRITE;
      end
      WRITE: begin
        if (wcnt_q == words_q - AW'(1)) begin
          state_d = START;
        end else begin
          wcnt_d  = wcnt_q + AW'(1);
          state_d = LOAD;
        end
      end
      START: begin
        rcnt_d  = '0;
        state_d = DECODE;
      end
      DECODE: begin
        if (done) state_d = RDADDR;
      end
      RDADDR: begin
        wait_d  = '0;
        state_d = RDWAIT;
      end
      RDWAIT: begin
        // Read data is valid on the last wait cycle; capture it then.
        if (wait_q == WW'(RDLAT - 1)) begin
          mdata_d = sign_bits;
          mlast_d = (rcnt_q == words_q - AW'(1));
          state_d = OUT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      OUT: begin
        if (m_ready) begin
          if (mlast_q) begin
            state_d = IDLE;
          end else begin
            rcnt_d  = rcnt_q + AW'(1);
            state_d = RDADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      words_q <= '0;
      mode_q  <= '0;
      iter_q  <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      wait_q  <= '0;
      mdata_q <= '0;
      mlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      mode_q  <= mode_d;
      iter_q  <= iter_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wait_q  <= wait_d;
      mdata_q <= mdata_d;
      mlast_q <= mlast_d;
    end
  end

  assign s_ready    = (state_q == LOAD);
  assign llr_access = (state_q == LOAD) || (state_q == WRITE) || (state_q == RDADDR) ||
                      (state_q == RDWAIT) || (state_q == OUT);
  assign llr_addr   = ((state_q == LOAD) || (state_q == WRITE)) ? wcnt_q :
                      ((state_q == RDADDR) || (state_q == RDWAIT) || (state_q == OUT)) ? rcnt_q :
                      '0;
  assign llr_din_we = (state_q == WRITE);
  assign start      = (state_q == START);
  assign mode       = mode_q;
  assign iter_limit = iter_q;
  assign m_valid    = (state_q == OUT);
  assign m_data     = mdata_q;
  assign m_last     = mlast_q && (state_q == OUT);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ldpc_io_sequencer.sv
// Directed bench for ldpc_io_sequencer with a small decoder-memory model behind the LLR port.
module tb_ldpc_io_sequencer;

  localparam int NI = 12;
  localparam int LW = 6;
  localparam int LN = 4;
  localparam int AW = 8;
  localparam int BEATS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               cfg_go = 0;
  logic [AW-1:0]      cfg_words = '0;
  logic [4:0]         cfg_mode = '0;
  logic [5:0]         cfg_iter = '0;
  logic               s_valid = 0;
  logic               s_ready;
  logic [LN*LW-1:0]   s_data = '0;
  logic               llr_access;
  logic [AW-1:0]      llr_addr;
  logic               llr_din_we;
  logic [NI*LW-1:0]   llr_din;
  logic [NI*LW-1:0]   llr_dout;
  logic               start;
  logic [4:0]         mode;
  logic [5:0]         iter_limit;
  logic               done = 0;
  logic               m_valid;
  logic               m_ready = 0;
  logic [NI-1:0]      m_data;
  logic               m_last;
  logic               busy;

  ldpc_io_sequencer #(
    .FOLDFACTOR(1), .NUMINSTANCES(NI), .LLRWIDTH(LW), .LANES(LN), .RDLAT(2)
  ) dut (
    .clk(clk), .rst(rst), .cfg_go(cfg_go), .cfg_words(cfg_words), .cfg_mode(cfg_mode),
    .cfg_iter(cfg_iter), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .llr_access(llr_access), .llr_addr(llr_addr), .llr_din_we(llr_din_we), .llr_din(llr_din),
    .llr_dout(llr_dout), .start(start), .mode(mode), .iter_limit(iter_limit), .done(done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  // Decoder memory model: two-cycle read latency from llr_addr to llr_dout.
  logic [NI*LW-1:0] mem [4];
  logic [AW-1:0]    a1 = '0, a2 = '0;
  always @(posedge clk) begin
    if (llr_din_we) mem[llr_addr[1:0]] <= llr_din;
    a1 <= llr_addr;
    a2 <= a1;
  end
  assign llr_dout = mem[a2[1:0]];

  int tests_run = 0;
  int tests_failed = 0;
  logic [NI-1:0] cap_data [4];
  logic          cap_last [4];
  logic [AW-1:0] cap_addr [4];

  // pat 0: LLR i = i; pat 1: even LLRs -1, odd +1; pat 2: per-word mix of the above.
  function automatic logic [5:0] llr_val(input int pat, input int w, input int i);
    if (pat == 0 || (pat == 2 && w == 0)) return 6'(i);
    if (pat == 1 || (pat == 2 && w == 1)) return (i % 2 == 0) ? 6'h3F : 6'h01;
    return (i < 6) ? 6'h3F : 6'h01;
  endfunction

  function automatic logic [NI*LW-1:0] exp_word(input int pat, input int w);
    logic [NI*LW-1:0] r;
    for (int i = 0; i < NI; i++) r[i*LW +: LW] = llr_val(pat, w, i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL timeout %s: waited 100 cycles, required event not seen", name);
  endtask

  task automatic go(input int words, input int md, input int it);
    cfg_words = AW'(words);
    cfg_mode  = 5'(md);
    cfg_iter  = 6'(it);
    cfg_go    = 1'b1;
    tick();
    cfg_go    = 1'b0;
  endtask

  task automatic send_beat(input int pat, input int w, input int b, input bit gap);
    int n;
    if (gap) begin
      s_valid = 1'b0;
      tick();
    end
    for (int l = 0; l < LN; l++) s_data[l*LW +: LW] = llr_val(pat, w, b*LN + l);
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    if (!s_ready) timeout_fail("s_ready");
    tick();
    s_valid = 1'b0;
  endtask

  task automatic load_word(input int pat, input int w, input bit gap);
    for (int b = 0; b < BEATS; b++) send_beat(pat, w, b, gap && b > 0);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!start && n < 100) begin
      tick();
      n++;
    end
    if (!start) timeout_fail("start");
  endtask

  task automatic decode_done(input int delay);
    repeat (delay) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_mvalid();
    int n = 0;
    while (!m_valid && n < 100) begin
      tick();
      n++;
    end
    if (!m_valid) timeout_fail("m_valid");
  endtask

  task automatic drain(input int nw);
    for (int k = 0; k < nw; k++) begin
      wait_mvalid();
      cap_data[k] = m_data;
      cap_last[k] = m_last;
      cap_addr[k] = llr_addr;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({s_ready, llr_access, llr_addr, llr_din_we, llr_din, start, mode, iter_limit,
         m_valid, m_data, m_last, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b s_ready=%b llr_din=%h, all zero required",
               busy, s_ready, llr_din);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_single_word();
    logic [23:0] low_lanes;
    go(1, 5'h0A, 6'h15);
    tests_run++;
    if ({busy, s_ready, llr_access} !== 3'b111) begin
      tests_failed++;
      $display("FAIL load_entry: busy,s_ready,access=%b, required 111", {busy, s_ready, llr_access});
    end
    load_word(0, 0, 0);
    tests_run++;
    if ({llr_din_we, llr_addr} !== {1'b1, 8'd0}) begin
      tests_failed++;
      $display("FAIL write1_addr: we=%b addr=%0d, required we=1 addr=0", llr_din_we, llr_addr);
    end
    low_lanes = llr_din[23:0];
    tests_run++;
    if (low_lanes !== {6'd3, 6'd2, 6'd1, 6'd0}) begin
      tests_failed++;
      $display("FAIL write1_lanes: beat0 slice=%h, required %h", low_lanes, {6'd3, 6'd2, 6'd1, 6'd0});
    end
    tests_run++;
    if (llr_din !== exp_word(0, 0)) begin
      tests_failed++;
      $display("FAIL write1_word: llr_din=%h, required %h", llr_din, exp_word(0, 0));
    end
    tick();
    tests_run++;
    if ({start, mode, iter_limit, llr_access, llr_din_we} !== {1'b1, 5'h0A, 6'h15, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL start_pulse: start=%b mode=%h iter=%h access=%b, required 1 0a 15 0",
               start, mode, iter_limit, llr_access);
    end
    tick();
    tests_run++;
    if ({start, mode, iter_limit, busy} !== {1'b0, 5'h0A, 6'h15, 1'b1}) begin
      tests_failed++;
      $display("FAIL start_once: start=%b mode=%h iter=%h, required 0 0a 15", start, mode, iter_limit);
    end
    decode_done(3);
    drain(1);
    tests_run++;
    if ({cap_data[0], cap_last[0], busy} !== {12'h000, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_read: m_data=%h last=%b busy=%b, required 000 1 0",
               cap_data[0], cap_last[0], busy);
    end
    $display("[TB] single word done");
  endtask

  task automatic test_backpressure();
    go(2, 5'h01, 6'h02);
    load_word(2, 0, 1);
    tests_run++;
    if ({s_ready, llr_din_we, llr_addr} !== {1'b0, 1'b1, 8'd0} || llr_din !== exp_word(2, 0)) begin
      tests_failed++;
      $display("FAIL bp_write0: s_ready=%b we=%b addr=%0d din=%h, required 0 1 0 %h",
               s_ready, llr_din_we, llr_addr, llr_din, exp_word(2, 0));
    end
    tick();
    load_word(2, 1, 1);
    tests_run++;
    if ({s_ready, llr_din_we, llr_addr} !== {1'b0, 1'b1, 8'd1} || llr_din !== exp_word(2, 1)) begin
      tests_failed++;
      $display("FAIL bp_write1: s_ready=%b we=%b addr=%0d din=%h, required 0 1 1 %h",
               s_ready, llr_din_we, llr_addr, llr_din, exp_word(2, 1));
    end
    tick();
    tests_run++;
    if ({start, s_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_start: start=%b s_ready=%b, required 1 0", start, s_ready);
    end
    tick();
    s_valid = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({s_ready, busy, start, llr_access, m_valid} !== 5'b01000) begin
      tests_failed++;
      $display("FAIL bp_decode_stray: s_ready,busy,start,access,m_valid=%b, required 01000",
               {s_ready, busy, start, llr_access, m_valid});
    end
    s_valid = 1'b0;
    decode_done(1);
    drain(2);
    tests_run++;
    if ({cap_data[0], cap_last[0], cap_data[1], cap_last[1]} !== {12'h000, 1'b0, 12'h555, 1'b1}) begin
      tests_failed++;
      $display("FAIL bp_read: w0=%h/%b w1=%h/%b, required 000/0 555/1",
               cap_data[0], cap_last[0], cap_data[1], cap_last[1]);
    end
    $display("[TB] backpressure done");
  endtask

  task automatic test_readback();
    go(1, 5'h03, 6'h04);
    load_word(1, 0, 0);
    wait_start();
    repeat (5) tick();
    done = 1'b1;
    tests_run++;
    if ({busy, llr_access, m_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL rb_waiting: busy,access,m_valid=%b, required 100", {busy, llr_access, m_valid});
    end
    tick();
    done = 1'b0;
    tests_run++;
    if ({llr_access, llr_addr, m_valid} !== {1'b1, 8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rb_rdaddr: access=%b addr=%0d m_valid=%b, required 1 0 0",
               llr_access, llr_addr, m_valid);
    end
    tick();
    tick();
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rb_wait: m_valid=%b during read wait, required 0", m_valid);
    end
    tick();
    tests_run++;
    if ({m_valid, m_data, m_last} !== {1'b1, 12'b010101010101, 1'b1}) begin
      tests_failed++;
      $display("FAIL rb_out: m_valid=%b m_data=%b m_last=%b, required 1 010101010101 1",
               m_valid, m_data, m_last);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tests_run++;
    if ({busy, m_valid, m_last} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rb_idle: busy,m_valid,m_last=%b, required 000", {busy, m_valid, m_last});
    end
    $display("[TB] readback done");
  endtask

  task automatic test_stall();
    go(3, 5'h07, 6'h08);
    for (int w = 0; w < 3; w++) load_word(2, w, 0);
    wait_start();
    decode_done(2);
    wait_mvalid();
    tests_run++;
    if ({m_data, m_last, llr_addr} !== {12'h000, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL stall_w0: m_data=%h last=%b addr=%0d, required 000 0 0", m_data, m_last, llr_addr);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    wait_mvalid();
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if ({m_valid, m_data, m_last, llr_addr} !== {1'b1, 12'h555, 1'b0, 8'd1}) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: m_valid=%b m_data=%h last=%b addr=%0d, required 1 555 0 1",
                 c, m_valid, m_data, m_last, llr_addr);
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    wait_mvalid();
    tests_run++;
    if ({m_data, m_last, llr_addr} !== {12'h03F, 1'b1, 8'd2}) begin
      tests_failed++;
      $display("FAIL stall_w2: m_data=%h last=%b addr=%0d, required 03f 1 2", m_data, m_last, llr_addr);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_end: busy=%b, required 0", busy);
    end
    $display("[TB] stall done");
  endtask

  task automatic test_config_edge();
    cfg_words = '0;
    cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    tick();
    tests_run++;
    if ({busy, s_ready, llr_access} !== 3'b000) begin
      tests_failed++;
      $display("FAIL cfg_zero: busy,s_ready,access=%b, required 000", {busy, s_ready, llr_access});
    end
    go(1, 5'h13, 6'h2A);
    load_word(0, 0, 0);
    wait_start();
    tick();
    cfg_words = AW'(2);
    cfg_mode  = 5'h1F;
    cfg_iter  = 6'h3F;
    cfg_go    = 1'b1;
    tick();
    cfg_go    = 1'b0;
    tick();
    tests_run++;
    if ({mode, iter_limit, busy, llr_access, start} !== {5'h13, 6'h2A, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL cfg_decode_go: mode=%h iter=%h busy=%b access=%b, required 13 2a 1 0",
               mode, iter_limit, busy, llr_access);
    end
    decode_done(1);
    drain(1);
    tests_run++;
    if ({cap_last[0], busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL cfg_frame_len: last=%b busy=%b, required 1 0", cap_last[0], busy);
    end
    $display("[TB] config edge done");
  endtask

  task automatic test_reset_mid_load();
    go(2, 5'h11, 6'h22);
    send_beat(1, 0, 0, 0);
    send_beat(1, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({s_ready, llr_access, llr_addr, llr_din_we, llr_din, start, mode, iter_limit,
         m_valid, m_data, m_last, busy} !== '0) begin
      tests_failed++;
      $display("FAIL midload_reset: busy=%b s_ready=%b mode=%h llr_din=%h, all zero required",
               busy, s_ready, mode, llr_din);
    end
    tick();
    rst = 1'b0;
    tick();
    go(1, 5'h05, 6'h07);
    load_word(0, 0, 0);
    tests_run++;
    if ({llr_din_we, llr_addr} !== {1'b1, 8'd0} || llr_din !== exp_word(0, 0)) begin
      tests_failed++;
      $display("FAIL midload_repack: we=%b addr=%0d din=%h, required 1 0 %h",
               llr_din_we, llr_addr, llr_din, exp_word(0, 0));
    end
    wait_start();
    decode_done(1);
    drain(1);
    tests_run++;
    if ({cap_data[0], cap_last[0], cap_addr[0]} !== {12'h000, 1'b1, 8'd0}) begin
      tests_failed++;
      $display("FAIL midload_read: m_data=%h last=%b addr=%0d, required 000 1 0",
               cap_data[0], cap_last[0], cap_addr[0]);
    end
    $display("[TB] reset mid-load done");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    test_reset();
    test_single_word();
    test_backpressure();
    test_readback();
    test_stall();
    test_config_edge();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
